credit_vend_ctrl: RTL

Parametrised successor to the single-coin 2-bit credit FSM. It accepts N_COIN debounced coin channels, each with its own programmable value, and accumulates credit up to CREDIT_MAX. On a buy request it vends at a fixed PRICE, then pays back any remaining credit as unit-change pulses over a req/ack handshake. It sits between the raw coin-slot pins and the dispenser/change-hopper drivers in the top-level wrapper.

---
 rtl/credit_pkg.sv | 40 ++++
 rtl/coin_debounce.sv | 55 +++++
 rtl/credit_vend_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/credit_pkg.sv
// credit_pkg: shared types and defaults for the credit vending controller.
//
// Contents:
//   state_e        controller state (ACCUM, VEND, CHANGE)
//   DEF_*          default parameter values for credit_vend_ctrl
//   coin_val()     extracts one channel's value from a packed coin-value vector
package credit_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        VEND,
        CHANGE
    } state_e;

    localparam int              DEF_N_COIN     = 3;
    localparam int              DEF_CREDIT_W   = 8;
    localparam logic [23:0]     DEF_COIN_VAL   = {8'd10, 8'd5, 8'd1};
    localparam int              DEF_PRICE      = 12;
    localparam int              DEF_CREDIT_MAX = 50;
    localparam int              DEF_DB_DEPTH   = 4;

    // Widest value slice and packed bus the helper accepts
    // (8 channels of up to 16 bits each).
    localparam int              VAL_MAX_W      = 16;
    localparam int              VAL_BUS_W      = 8 * VAL_MAX_W;

    // Returns slice [idx*width +: width] of vals, zero-extended to VAL_MAX_W.
    function automatic logic [VAL_MAX_W-1:0] coin_val(
        input logic [VAL_BUS_W-1:0] vals,
        input int unsigned          width,
        input int unsigned          idx
    );
        logic [VAL_BUS_W-1:0] shifted;
        logic [VAL_MAX_W-1:0] mask;
        shifted = vals >> (idx * width);
        mask    = VAL_MAX_W'((32'd1 << width) - 32'd1);
        return shifted[VAL_MAX_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one coin channel front end.
//
// A 2-flop synchroniser feeds a DB_DEPTH-deep shift register. The debounced
// level sets only when every sample is 1 and clears only when every sample
// is 0; mixed windows hold the previous level.
//
// Ports:
//   clk        clock
//   rst_i      asynchronous active-high reset
//   coin_raw   asynchronous coin-slot level
//   coin_rise  one-cycle pulse, the debounced level is about to rise
//
// DB_DEPTH must be at least 2.
module coin_debounce #(
    parameter int DB_DEPTH = 4
) (
    input  logic clk,
    input  logic rst_i,
    input  logic coin_raw,
    output logic coin_rise
);

    logic                sync1;
    logic                sync2;
    logic [DB_DEPTH-1:0] shreg;
    logic                level;
    logic                all_one;
    logic                all_zero;

    assign all_one  = &shreg;
    assign all_zero = ~|shreg;

    // The rise is taken from the window rather than from the level register
    // so the pending bit upstream is set on the same edge the level rises.
    assign coin_rise = all_one & ~level;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            shreg <= '0;
            level <= 1'b0;
        end else begin
            sync1 <= coin_raw;
            sync2 <= sync1;
            shreg <= {shreg[DB_DEPTH-2:0], sync2};
            if (all_one) begin
                level <= 1'b1;
            end else if (all_zero) begin
                level <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/credit_vend_ctrl.sv
// credit_vend_ctrl: multi-channel coin credit accumulator with fixed-price
// vend and unit-change payback over a req/ack handshake.
//
// Ports:
//   clk, rst_i      clock, asynchronous active-high reset
//   coin_raw_i      asynchronous coin-slot levels, one per channel
//   buy_i           one-cycle buy request
//   cancel_i        one-cycle cancel/refund request (wins over buy_i)
//   change_ack_i    hopper accepted one unit of change
//   credit_o        current credit
//   vend_o          one-cycle dispense pulse
//   short_o         one-cycle pulse, buy refused for insufficient credit
//   change_req_o    unit-change request
//   busy_o          controller is vending or paying change
//   reject_o        one-cycle coin reject pulse
//   reject_ch_o     channel index of the rejected coin
//
// Build option: define COIN_REJECT_EN to reject coins that would push credit
// above CREDIT_MAX; otherwise credit saturates and reject_o/reject_ch_o stay 0.
module credit_vend_ctrl
    import credit_pkg::*;
#(
    parameter int                          N_COIN     = DEF_N_COIN,
    parameter int                          CREDIT_W   = DEF_CREDIT_W,
    parameter logic [N_COIN*CREDIT_W-1:0]  COIN_VAL   = DEF_COIN_VAL,
    parameter int                          PRICE      = DEF_PRICE,
    parameter int                          CREDIT_MAX = DEF_CREDIT_MAX,
    parameter int                          DB_DEPTH   = DEF_DB_DEPTH
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [N_COIN-1:0]   coin_raw_i,
    input  logic                buy_i,
    input  logic                cancel_i,
    input  logic                change_ack_i,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                vend_o,
    output logic                short_o,
    output logic                change_req_o,
    output logic                busy_o,
    output logic                reject_o,
    output logic [2:0]          reject_ch_o
);

    state_e              state;
    logic [N_COIN-1:0]   coin_rise;
    logic [N_COIN-1:0]   pending;
    logic [CREDIT_W-1:0] val_tab [N_COIN];

    logic                add_valid;
    logic [N_COIN-1:0]   add_mask;
    logic [CREDIT_W-1:0] add_val;
    logic [CREDIT_W:0]   sum;
    logic                over;
    logic                take_coin;
`ifdef COIN_REJECT_EN
    logic [2:0]          sel_idx;
`endif

    for (genvar g = 0; g < N_COIN; g++) begin : g_coin
        coin_debounce #(
            .DB_DEPTH (DB_DEPTH)
        ) u_db (
            .clk       (clk),
            .rst_i     (rst_i),
            .coin_raw  (coin_raw_i[g]),
            .coin_rise (coin_rise[g])
        );
        assign val_tab[g] = CREDIT_W'(coin_val(VAL_BUS_W'(COIN_VAL), CREDIT_W, g));
    end

    // Lowest-index pending coin wins; scanning downward lets the last hit stick.
    // A buy or cancel in ACCUM takes the cycle, so the coin waits in pending.
    always_comb begin
        add_valid = 1'b0;
        add_mask  = '0;
        add_val   = '0;
`ifdef COIN_REJECT_EN
        sel_idx   = '0;
`endif
        for (int i = N_COIN - 1; i >= 0; i--) begin
            if (pending[i]) begin
                add_valid = 1'b1;
                add_mask  = N_COIN'(1) << i;
                add_val   = val_tab[i];
`ifdef COIN_REJECT_EN
                sel_idx   = 3'(i);
`endif
            end
        end
        sum       = {1'b0, credit_o} + {1'b0, add_val};
        over      = sum > (CREDIT_W+1)'(CREDIT_MAX);
        take_coin = (state == ACCUM) && !buy_i && !cancel_i && add_valid;
    end

`ifndef COIN_REJECT_EN
    assign reject_o    = 1'b0;
    assign reject_ch_o = 3'd0;
`endif

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state        <= ACCUM;
            pending      <= '0;
            credit_o     <= '0;
            vend_o       <= 1'b0;
            short_o      <= 1'b0;
            change_req_o <= 1'b0;
            busy_o       <= 1'b0;
`ifdef COIN_REJECT_EN
            reject_o     <= 1'b0;
            reject_ch_o  <= 3'd0;
`endif
        end else begin
            vend_o  <= 1'b0;
            short_o <= 1'b0;
`ifdef COIN_REJECT_EN
            reject_o    <= 1'b0;
            reject_ch_o <= 3'd0;
`endif
            // New rises are ORed in after the clear so none is ever dropped.
            pending <= (pending & ~(take_coin ? add_mask : '0)) | coin_rise;

            case (state)
                ACCUM: begin
                    if (cancel_i) begin
                        if (credit_o != '0) begin
                            state        <= CHANGE;
                            busy_o       <= 1'b1;
                            change_req_o <= 1'b1;
                        end
                    end else if (buy_i) begin
                        if (credit_o >= CREDIT_W'(PRICE)) begin
                            state    <= VEND;
                            busy_o   <= 1'b1;
                            vend_o   <= 1'b1;
                            credit_o <= credit_o - CREDIT_W'(PRICE);
                        end else begin
                            short_o <= 1'b1;
                        end
                    end else if (take_coin) begin
                        if (!over) begin
                            credit_o <= sum[CREDIT_W-1:0];
                        end else begin
`ifdef COIN_REJECT_EN
                            reject_o    <= 1'b1;
                            reject_ch_o <= sel_idx;
`else
                            credit_o    <= CREDIT_W'(CREDIT_MAX);
`endif
                        end
                    end
                end
                // vend_o and the price deduction were issued on entry, so
                // credit here is already the leftover to pay back.
                VEND: begin
                    if (credit_o != '0) begin
                        state        <= CHANGE;
                        change_req_o <= 1'b1;
                    end else begin
                        state  <= ACCUM;
                        busy_o <= 1'b0;
                    end
                end
                CHANGE: begin
                    if (credit_o == '0) begin
                        state        <= ACCUM;
                        busy_o       <= 1'b0;
                        change_req_o <= 1'b0;
                    end else if (change_req_o && change_ack_i) begin
                        credit_o <= credit_o - CREDIT_W'(1);
                        if (credit_o == CREDIT_W'(1)) begin
                            state        <= ACCUM;
                            busy_o       <= 1'b0;
                            change_req_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= ACCUM;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
